boundary_scan_chain: RTL and testbench
======================================

// Module: boundary_scan_chain
// PURPOSE
//  Parametrised boundary-scan register: WIDTH capture/shift/update cells in one serial chain (TDI -> TDO).
//  Observes (capture) and drives (update + testNorm) WIDTH functional pins between core logic and pads.
//  Counts shifted bits and flags partial-shift updates.
// PARAMETERS
//  WIDTH      8   number of boundary cells in the chain (>= 2)
//  UPD_RESET  0   WIDTH-bit reset value of the update register
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  normIn     in   WIDTH    functional inputs from core/pad
//  normOut    out  WIDTH    functional outputs to pad/core
//  TDI        in   1        serial scan data in
//  TDO        out  1        serial scan data out
//  captureDR  in   1        load normIn into shift register
//  shiftDR    in   1        shift chain one bit
//  updateDR   in   1        copy shift register to update register
//  testNorm   in   1        1 = drive normOut from update register, 0 = pass normIn
//  shiftCnt   out  $clog2(WIDTH+1)  bits shifted since last capture/reset, saturates at WIDTH
//  chainFull  out  1        shiftCnt == WIDTH
//  updateErr  out  1        one-cycle pulse: update issued with 0 < shiftCnt < WIDTH
// BEHAVIOUR
//  - Clock clk, reset rst: synchronous, active-high; sampled on rising clk only.
//  - Reset: sr = 0, upd = UPD_RESET, shiftCnt = 0, updateErr = 0; TDO = 0; normOut per testNorm mux.
//  - Shift register sr[WIDTH-1:0]; TDO = sr[0] (registered, no comb path from TDI).
//  - Shift: sr <= {TDI, sr[WIDTH-1:1]}; after WIDTH shifts first TDI bit sits in sr[0].
//  - Capture: sr <= normIn; shiftCnt <= 0.
//  - Priority: rst > captureDR > shiftDR; capture+shift same cycle -> capture only, no shift, cnt = 0.
//  - Shift: shiftCnt <= min(shiftCnt+1, WIDTH); extra shifts keep shifting data, cnt stays WIDTH.
//  - Update: upd <= sr value before this edge (shift/capture in same cycle does not affect it).
//  - Update always applied; updateErr = 1 next cycle iff 0 < shiftCnt < WIDTH at the update edge.
//  - updateErr otherwise 0; never sticky.
//  - normOut = testNorm ? upd : normIn (combinational, zero latency; testNorm change visible same cycle).
//  - Latency: TDI bit to TDO = WIDTH shift cycles; update to normOut = 1 clk (when testNorm = 1).
//  - rst mid-shift: chain contents and count discarded; upd returns to UPD_RESET.
//  - No control asserted: all state holds.
// CONFIGURATION
//  BSC_BYPASS_EN defined:
//   - adds input bypassSel (1) and 1-bit bypass register byp (reset 0).
//   - bypassSel=1: captureDR loads byp <= 0; shiftDR loads byp <= TDI; TDO = byp.
//   - bypassSel=1: sr, shiftCnt, upd untouched; updateDR ignored, updateErr stays 0.
//   - bypassSel=0: identical to non-bypass build; byp holds.
//  BSC_BYPASS_EN undefined: no bypassSel port, no byp; TDO = sr[0] always.
// TESTING  (WIDTH=8, UPD_RESET=0 unless stated)
//  1 Reset: rst=1 one clk with random inputs -> TDO=0, shiftCnt=0, updateErr=0, testNorm=1 gives normOut=8'h00.
//  2 Capture/shift out: normIn=8'hA5, captureDR 1 clk, then shiftDR 8 clk.
//    -> TDO sequence 1,0,1,0,0,1,0,1 (LSB first); chainFull=1 after 8th shift.
//  3 Shift in/update: shift TDI bits 1,1,0,0,1,0,1,1 (8 clk), updateDR, testNorm=1 -> normOut=8'hD3 next cycle.
//    testNorm=0 -> normOut=normIn same cycle.
//  4 Partial update: capture, shift 3, updateDR -> updateErr=1 for exactly one cycle.
//    upd = partially shifted sr; shiftCnt=3.
//  5 Simultaneous: captureDR+shiftDR with normIn=8'h3C -> sr=8'h3C, shiftCnt=0.
//    update+shift same edge -> upd gets pre-shift value.
//  6 BSC_BYPASS_EN build: bypassSel=1, shift TDI=1 -> TDO=1 after 1 clk; updateDR -> upd unchanged, updateErr=0.
//    rst mid-shift -> byp=0.

Source files
------------

// File: rtl/boundary_scan_chain.sv
// Boundary-scan register: WIDTH capture/shift/update cells, serial TDI -> TDO, with shift counter and partial-update flag.
// Optional feature macro: BSC_BYPASS_EN (adds bypassSel input and a 1-bit bypass register in front of TDO).
module boundary_scan_chain #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] UPD_RESET = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           normIn,
    output logic [WIDTH-1:0]           normOut,
    input  logic                       TDI,
    output logic                       TDO,
    input  logic                       captureDR,
    input  logic                       shiftDR,
    input  logic                       updateDR,
    input  logic                       testNorm,
`ifdef BSC_BYPASS_EN
    input  logic                       bypassSel,
`endif
    output logic [$clog2(WIDTH+1)-1:0] shiftCnt,
    output logic                       chainFull,
    output logic                       updateErr
);

    localparam int                CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] upd;
    logic             bypass_active;

`ifdef BSC_BYPASS_EN
    logic byp;

    assign bypass_active = bypassSel;

    always_ff @(posedge clk) begin
        if (rst) begin
            byp <= 1'b0;
        end else if (bypassSel) begin
            if (captureDR) begin
                byp <= 1'b0;
            end else if (shiftDR) begin
                byp <= TDI;
            end
        end
    end

    assign TDO = bypassSel ? byp : sr[0];
`else
    assign bypass_active = 1'b0;
    assign TDO           = sr[0];
`endif

    // Update samples the pre-edge chain, so a same-cycle shift/capture cannot leak into upd.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            upd       <= UPD_RESET;
            shiftCnt  <= '0;
            updateErr <= 1'b0;
        end else begin
            updateErr <= 1'b0;
            if (!bypass_active) begin
                if (updateDR) begin
                    upd       <= sr;
                    updateErr <= (shiftCnt != '0) && (shiftCnt < CNT_MAX);
                end
                if (captureDR) begin
                    sr       <= normIn;
                    shiftCnt <= '0;
                end else if (shiftDR) begin
                    sr <= {TDI, sr[WIDTH-1:1]};
                    if (shiftCnt < CNT_MAX) begin
                        shiftCnt <= shiftCnt + 1'b1;
                    end
                end
            end
        end
    end

    assign chainFull = (shiftCnt == CNT_MAX);
    assign normOut   = testNorm ? upd : normIn;

endmodule

// File: tb/tb_boundary_scan_chain.sv
// Directed bench for boundary_scan_chain (WIDTH=8, UPD_RESET=0); bypass steps are built only with BSC_BYPASS_EN.
module tb_boundary_scan_chain;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] normIn;
    logic [7:0] normOut;
    logic       TDI;
    logic       TDO;
    logic       captureDR;
    logic       shiftDR;
    logic       updateDR;
    logic       testNorm;
    logic [3:0] shiftCnt;
    logic       chainFull;
    logic       updateErr;
`ifdef BSC_BYPASS_EN
    logic       bypassSel;
`endif

    int compared   = 0;
    int mismatched = 0;

    boundary_scan_chain #(.WIDTH(8), .UPD_RESET(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .normIn    (normIn),
        .normOut   (normOut),
        .TDI       (TDI),
        .TDO       (TDO),
        .captureDR (captureDR),
        .shiftDR   (shiftDR),
        .updateDR  (updateDR),
        .testNorm  (testNorm),
`ifdef BSC_BYPASS_EN
        .bypassSel (bypassSel),
`endif
        .shiftCnt  (shiftCnt),
        .chainFull (chainFull),
        .updateErr (updateErr)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] pat;

        // Reset with arbitrary inputs
        rst = 1'b1; normIn = 8'($urandom); TDI = 1'($urandom);
        captureDR = 1'($urandom); shiftDR = 1'($urandom); updateDR = 1'($urandom);
        testNorm = 1'b1;
`ifdef BSC_BYPASS_EN
        bypassSel = 1'b0;
`endif
        tick();
        rst = 1'b0; captureDR = 1'b0; shiftDR = 1'b0; updateDR = 1'b0; TDI = 1'b0;
        #1;
        chk("rst_tdo", 32'(TDO), 32'h0);
        chk("rst_cnt", 32'(shiftCnt), 32'h0);
        chk("rst_err", 32'(updateErr), 32'h0);
        chk("rst_full", 32'(chainFull), 32'h0);
        chk("rst_normout", 32'(normOut), 32'h00);

        // Capture A5 and shift it out LSB first
        normIn = 8'hA5; captureDR = 1'b1;
        tick();
        captureDR = 1'b0;
        chk("cap_cnt", 32'(shiftCnt), 32'h0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("shout_tdo%0d", i), 32'(TDO), 32'(pat[i]));
            shiftDR = 1'b1; TDI = 1'b0;
            tick();
        end
        shiftDR = 1'b0;
        chk("shout_cnt", 32'(shiftCnt), 32'h8);
        chk("shout_full", 32'(chainFull), 32'h1);

        // Shift in D3; count stays saturated at WIDTH
        pat = 8'hD3;
        for (int i = 0; i < 8; i++) begin
            shiftDR = 1'b1; TDI = pat[i];
            tick();
        end
        shiftDR = 1'b0; TDI = 1'b0;
        chk("shin_cnt_sat", 32'(shiftCnt), 32'h8);
        chk("shin_tdo", 32'(TDO), 32'h1);
        #1;
        chk("pre_upd_normout", 32'(normOut), 32'h00);
        updateDR = 1'b1;
        tick();
        updateDR = 1'b0;
        chk("upd_normout", 32'(normOut), 32'hD3);
        chk("upd_err_full", 32'(updateErr), 32'h0);
        testNorm = 1'b0; normIn = 8'h5A;
        #1;
        chk("passthru", 32'(normOut), 32'h5A);
        testNorm = 1'b1;
        #1;
        chk("testnorm_back", 32'(normOut), 32'hD3);

        // Update right after capture (count 0) is not an error
        normIn = 8'hF0; captureDR = 1'b1;
        tick();
        captureDR = 1'b0; updateDR = 1'b1;
        tick();
        updateDR = 1'b0;
        chk("upd0_err", 32'(updateErr), 32'h0);
        chk("upd0_normout", 32'(normOut), 32'hF0);

        // Partial shift (3 bits of 1) then update -> one-cycle error pulse
        for (int i = 0; i < 3; i++) begin
            shiftDR = 1'b1; TDI = 1'b1;
            tick();
        end
        shiftDR = 1'b0; TDI = 1'b0; updateDR = 1'b1;
        tick();
        updateDR = 1'b0;
        chk("part_err", 32'(updateErr), 32'h1);
        chk("part_normout", 32'(normOut), 32'hFE);
        chk("part_cnt", 32'(shiftCnt), 32'h3);
        tick();
        chk("part_err_clr", 32'(updateErr), 32'h0);

        // Capture and shift together -> capture wins
        normIn = 8'h3C; captureDR = 1'b1; shiftDR = 1'b1; TDI = 1'b1;
        tick();
        captureDR = 1'b0;
        chk("sim_cnt", 32'(shiftCnt), 32'h0);
        chk("sim_tdo", 32'(TDO), 32'h0);
        // Update and shift together -> upd takes pre-shift 3C, sr becomes 9E
        updateDR = 1'b1;
        tick();
        updateDR = 1'b0; shiftDR = 1'b0;
        chk("updsh_normout", 32'(normOut), 32'h3C);
        chk("updsh_cnt", 32'(shiftCnt), 32'h1);
        chk("updsh_err", 32'(updateErr), 32'h0);
        shiftDR = 1'b1; TDI = 1'b0;
        tick();
        shiftDR = 1'b0;
        chk("updsh_sr_bit1", 32'(TDO), 32'h1);

        // Idle: everything holds
        tick(); tick();
        chk("hold_cnt", 32'(shiftCnt), 32'h2);
        chk("hold_normout", 32'(normOut), 32'h3C);

        // Reset in the middle of shifting
        shiftDR = 1'b1; TDI = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; shiftDR = 1'b0; TDI = 1'b0;
        chk("rstmid_cnt", 32'(shiftCnt), 32'h0);
        chk("rstmid_tdo", 32'(TDO), 32'h0);
        chk("rstmid_normout", 32'(normOut), 32'h00);

`ifdef BSC_BYPASS_EN
        // Load the chain with something visible first
        normIn = 8'h81; captureDR = 1'b1;
        tick();
        captureDR = 1'b0; updateDR = 1'b1;
        tick();
        updateDR = 1'b0;
        bypassSel = 1'b1; shiftDR = 1'b1; TDI = 1'b1;
        tick();
        shiftDR = 1'b0;
        chk("byp_tdo", 32'(TDO), 32'h1);
        chk("byp_cnt", 32'(shiftCnt), 32'h0);
        updateDR = 1'b1; shiftDR = 1'b1; TDI = 1'b0;
        tick();
        updateDR = 1'b0; shiftDR = 1'b0;
        chk("byp_upd_normout", 32'(normOut), 32'h81);
        chk("byp_upd_err", 32'(updateErr), 32'h0);
        chk("byp_tdo0", 32'(TDO), 32'h0);
        shiftDR = 1'b1; TDI = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; shiftDR = 1'b0; TDI = 1'b0;
        chk("byp_rst_tdo", 32'(TDO), 32'h0);
        bypassSel = 1'b0;
        #1;
        chk("byp_off_normout", 32'(normOut), 32'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
